// File: rtl/ioctl_load_sequencer.sv
// ioctl_load_sequencer
//   Controller for the hps_io ioctl download path of the arcade core. Each
//   download is decoded by ioctl_index (0 = ROM image, 1 = game-select byte,
//   254 = DIP bank, anything else ignored). The core is held in reset for the
//   whole download and for HOLD_CYCLES clocks after it ends.
//
// Parameters
//   ROM_SIZE     ROM bytes accepted; writes at addr >= ROM_SIZE are dropped
//   HOLD_CYCLES  clocks core_reset stays high after ioctl_download falls (>=1)
//   DIP_DEFAULT  reset value of the 8 DIP bytes (byte n = bits [8n+7:8n])
//
// Ports
//   clk_25, reset                 clock, async active-high reset
//   ioctl_download/wr/addr/dout/index   hps_io download interface
//   rom_wr/rom_addr/rom_data      registered ROM write port (latency 1)
//   mod, mod_onehot, mod_bad      game-select byte and its decode
//   sw_flat                       DIP bytes
//   rom_ovf                       sticky out-of-range ROM write flag
//   dl_busy, core_reset           sequencer busy / core reset
//   rom_sum                       16-bit sum of accepted ROM bytes
//                                 (only with IOCTL_ROM_CHECKSUM_EN defined)
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | no download, core running
// S_ROM   | ROM image download, writes go to the ROM port
// S_MOD   | game-select download, addr 0 captured into mod
// S_DIP   | DIP bank download, addr 0..7 land in sw_flat
// S_OTHER | unknown index, writes ignored
// S_HOLD  | download over, core still held for the settle interval

module ioctl_load_sequencer #(
  parameter int          ROM_SIZE    = 65536,
  parameter int          HOLD_CYCLES = 256,
  parameter logic [63:0] DIP_DEFAULT = 64'h0
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        rom_wr,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [7:0]  mod,
  output logic [3:0]  mod_onehot,
  output logic        mod_bad,
  output logic [63:0] sw_flat,
  output logic        rom_ovf,
`ifdef IOCTL_ROM_CHECKSUM_EN
  output logic [15:0] rom_sum,
`endif
  output logic        dl_busy,
  output logic        core_reset
);

  localparam int          HCW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);
  localparam logic [25:0] ROM_LIMIT = 26'(ROM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_ROM, S_MOD, S_DIP, S_OTHER, S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
  logic            rom_wr_q, rom_wr_d;
  logic [15:0]     rom_addr_q, rom_addr_d;
  logic [7:0]      rom_data_q, rom_data_d;
  logic [7:0]      mod_q, mod_d;
  logic [3:0]      mod_onehot_q, mod_onehot_d;
  logic            mod_bad_q, mod_bad_d;
  logic [63:0]     sw_flat_q, sw_flat_d;
  logic            rom_ovf_q, rom_ovf_d;

  state_t          idx_target;
  state_t          wr_target;
  logic            entering;
  logic            rom_entry;
  logic            rom_in_range;

  always_comb begin
    case (ioctl_index)
      8'd0:    idx_target = S_ROM;
      8'd1:    idx_target = S_MOD;
      8'd254:  idx_target = S_DIP;
      default: idx_target = S_OTHER;
    endcase
  end

  // A write on the entry cycle is decoded with the new index; otherwise the
  // latched state decides, so index changes mid-download have no effect.
  always_comb begin
    entering  = ((state_q == S_IDLE) || (state_q == S_HOLD)) && ioctl_download;
    wr_target = state_q;
    if (entering) wr_target = idx_target;
    rom_entry    = entering && (idx_target == S_ROM);
    rom_in_range = ({1'b0, ioctl_addr} < ROM_LIMIT);
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ioctl_download) state_d = idx_target;
      end
      S_HOLD: begin
        if (ioctl_download) begin
          state_d    = idx_target;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: begin
        if (!ioctl_download) begin
          state_d    = S_HOLD;
          hold_cnt_d = HOLD_LOAD;
        end
      end
    endcase
  end

  always_comb begin
    rom_wr_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    rom_ovf_d  = rom_entry ? 1'b0 : rom_ovf_q;
    mod_d      = mod_q;
    sw_flat_d  = sw_flat_q;

    if (ioctl_wr) begin
      case (wr_target)
        S_ROM: begin
          if (rom_in_range) begin
            rom_wr_d   = 1'b1;
            rom_addr_d = ioctl_addr[15:0];
            rom_data_d = ioctl_dout;
          end else begin
            rom_ovf_d = 1'b1;
          end
        end
        S_MOD: begin
          if (ioctl_addr == '0) mod_d = ioctl_dout;
        end
        S_DIP: begin
          if (ioctl_addr[24:3] == '0) sw_flat_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
        end
        default: ;
      endcase
    end

    // Decode trails the captured byte by one cycle.
    case (mod_q)
      8'd0:    mod_onehot_d = 4'b0001;
      8'd1:    mod_onehot_d = 4'b0010;
      8'd2:    mod_onehot_d = 4'b0100;
      8'd3:    mod_onehot_d = 4'b1000;
      default: mod_onehot_d = 4'b0000;
    endcase
    mod_bad_d = (mod_q > 8'd3);
  end

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hold_cnt_q   <= '0;
      rom_wr_q     <= 1'b0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      mod_q        <= '0;
      mod_onehot_q <= 4'b0001;
      mod_bad_q    <= 1'b0;
      sw_flat_q    <= DIP_DEFAULT;
      rom_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      rom_wr_q     <= rom_wr_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      mod_q        <= mod_d;
      mod_onehot_q <= mod_onehot_d;
      mod_bad_q    <= mod_bad_d;
      sw_flat_q    <= sw_flat_d;
      rom_ovf_q    <= rom_ovf_d;
    end
  end

`ifdef IOCTL_ROM_CHECKSUM_EN
  logic [15:0] rom_sum_q, rom_sum_d;

  // Accumulates off the registered strobe; a clear on ROM entry wins over a
  // trailing strobe from the previous load.
  always_comb begin
    rom_sum_d = rom_sum_q;
    if (rom_entry)     rom_sum_d = '0;
    else if (rom_wr_q) rom_sum_d = rom_sum_q + {8'h00, rom_data_q};
  end

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) rom_sum_q <= '0;
    else       rom_sum_q <= rom_sum_d;
  end

  assign rom_sum = rom_sum_q;
`endif

  assign rom_wr     = rom_wr_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign mod        = mod_q;
  assign mod_onehot = mod_onehot_q;
  assign mod_bad    = mod_bad_q;
  assign sw_flat    = sw_flat_q;
  assign rom_ovf    = rom_ovf_q;
  assign dl_busy    = (state_q != S_IDLE);
  assign core_reset = reset | dl_busy;

endmodule

// File: tb/tb_ioctl_load_sequencer.sv
module tb_ioctl_load_sequencer;

  localparam logic [63:0] DIPD = 64'h0123_4567_89AB_CDEF;

  logic        clk_25 = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic        rom_wr;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  mod;
  logic [3:0]  mod_onehot;
  logic        mod_bad;
  logic [63:0] sw_flat;
  logic        rom_ovf;
  logic        dl_busy;
  logic        core_reset;
`ifdef IOCTL_ROM_CHECKSUM_EN
  logic [15:0] rom_sum;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_25 = ~clk_25;

  ioctl_load_sequencer #(
    .ROM_SIZE(16),
    .HOLD_CYCLES(4),
    .DIP_DEFAULT(DIPD)
  ) dut (
    .clk_25(clk_25),
    .reset(reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index),
    .rom_wr(rom_wr),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .mod(mod),
    .mod_onehot(mod_onehot),
    .mod_bad(mod_bad),
    .sw_flat(sw_flat),
    .rom_ovf(rom_ovf),
`ifdef IOCTL_ROM_CHECKSUM_EN
    .rom_sum(rom_sum),
`endif
    .dl_busy(dl_busy),
    .core_reset(core_reset)
  );

  task automatic tick();
    @(negedge clk_25);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  // Fall edge plus HOLD_CYCLES=4 edges brings the FSM back to IDLE.
  task automatic finish_dl();
    ioctl_download = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    tick();
    vectors++; if (core_reset !== 1'b1) begin miscompares++; $display("FAIL rst_core_reset: got %b expected 1", core_reset); end
    vectors++; if (rom_wr !== 1'b0 || rom_addr !== 16'h0 || rom_data !== 8'h0) begin miscompares++; $display("FAIL rst_rom_port: got %b/%h/%h expected 0/0000/00", rom_wr, rom_addr, rom_data); end
    vectors++; if (mod !== 8'h0 || mod_onehot !== 4'b0001 || mod_bad !== 1'b0) begin miscompares++; $display("FAIL rst_mod: got %h/%b/%b expected 00/0001/0", mod, mod_onehot, mod_bad); end
    vectors++; if (sw_flat !== DIPD) begin miscompares++; $display("FAIL rst_sw_flat: got %h expected %h", sw_flat, DIPD); end
    vectors++; if (rom_ovf !== 1'b0 || dl_busy !== 1'b0) begin miscompares++; $display("FAIL rst_flags: got ovf=%b busy=%b expected 0/0", rom_ovf, dl_busy); end
    reset = 1'b0;
    tick();
    vectors++; if (core_reset !== 1'b0) begin miscompares++; $display("FAIL rst_release: got core_reset=%b expected 0", core_reset); end
  endtask

  task automatic test_rom_basic();
    start_dl(8'd0);
    vectors++; if (dl_busy !== 1'b1 || core_reset !== 1'b1) begin miscompares++; $display("FAIL rom_busy: got %b/%b expected 1/1", dl_busy, core_reset); end
    wr(25'd0, 8'hA5);
    vectors++; if (rom_wr !== 1'b1 || rom_addr !== 16'h0 || rom_data !== 8'hA5) begin miscompares++; $display("FAIL rom_wr0: got %b/%h/%h expected 1/0000/a5", rom_wr, rom_addr, rom_data); end
    tick();
    vectors++; if (rom_wr !== 1'b0) begin miscompares++; $display("FAIL rom_pulse_width: got %b expected 0", rom_wr); end
    wr(25'd1, 8'h3C);
    vectors++; if (rom_wr !== 1'b1 || rom_addr !== 16'h1 || rom_data !== 8'h3C) begin miscompares++; $display("FAIL rom_wr1: got %b/%h/%h expected 1/0001/3c", rom_wr, rom_addr, rom_data); end
    tick();
    vectors++; if (rom_ovf !== 1'b0 || rom_wr !== 1'b0) begin miscompares++; $display("FAIL rom_after: got ovf=%b wr=%b expected 0/0", rom_ovf, rom_wr); end
    finish_dl();
    vectors++; if (dl_busy !== 1'b0 || core_reset !== 1'b0) begin miscompares++; $display("FAIL rom_idle: got %b/%b expected 0/0", dl_busy, core_reset); end
  endtask

  task automatic test_rom_overflow();
    start_dl(8'd0);
    wr(25'd15, 8'h77);
    vectors++; if (rom_wr !== 1'b1 || rom_addr !== 16'hF || rom_data !== 8'h77) begin miscompares++; $display("FAIL ovf_last_ok: got %b/%h/%h expected 1/000f/77", rom_wr, rom_addr, rom_data); end
    tick();
    wr(25'd16, 8'hFF);
    vectors++; if (rom_wr !== 1'b0 || rom_ovf !== 1'b1 || rom_data !== 8'h77) begin miscompares++; $display("FAIL ovf_drop: got wr=%b ovf=%b data=%h expected 0/1/77", rom_wr, rom_ovf, rom_data); end
    finish_dl();
    vectors++; if (rom_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b expected 1", rom_ovf); end
    start_dl(8'd0);
    vectors++; if (rom_ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b expected 0", rom_ovf); end
    finish_dl();
  endtask

  task automatic test_mod();
    start_dl(8'd1);
    wr(25'd0, 8'h02);
    vectors++; if (mod !== 8'h02 || rom_wr !== 1'b0) begin miscompares++; $display("FAIL mod_cap: got mod=%h wr=%b expected 02/0", mod, rom_wr); end
    tick();
    vectors++; if (mod_onehot !== 4'b0100 || mod_bad !== 1'b0) begin miscompares++; $display("FAIL mod_dec2: got %b/%b expected 0100/0", mod_onehot, mod_bad); end
    ioctl_index = 8'd0;
    wr(25'd1, 8'h03);
    vectors++; if (mod !== 8'h02 || rom_wr !== 1'b0) begin miscompares++; $display("FAIL mod_ignore: got mod=%h wr=%b expected 02/0", mod, rom_wr); end
    wr(25'd0, 8'h07);
    tick();
    vectors++; if (mod !== 8'h07 || mod_onehot !== 4'b0000 || mod_bad !== 1'b1) begin miscompares++; $display("FAIL mod_bad: got %h/%b/%b expected 07/0000/1", mod, mod_onehot, mod_bad); end
    finish_dl();
  endtask

  task automatic test_dip();
    logic [63:0] exp;
    exp = DIPD;
    exp[31:24] = 8'h5A;
    start_dl(8'd254);
    wr(25'd3, 8'h5A);
    wr(25'd8, 8'h11);
    tick();
    vectors++; if (sw_flat !== exp) begin miscompares++; $display("FAIL dip_write: got %h expected %h", sw_flat, exp); end
    finish_dl();
  endtask

  task automatic test_hold();
    start_dl(8'd0);
    ioctl_download = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (core_reset !== 1'b1) begin miscompares++; $display("FAIL hold_high_%0d: got %b expected 1", i, core_reset); end
    end
    tick();
    vectors++; if (core_reset !== 1'b0) begin miscompares++; $display("FAIL hold_release: got %b expected 0", core_reset); end
    start_dl(8'd0);
    ioctl_download = 1'b0;
    tick();
    tick();
    ioctl_download = 1'b1;
    tick();
    repeat (4) tick();
    vectors++; if (core_reset !== 1'b1 || dl_busy !== 1'b1) begin miscompares++; $display("FAIL hold_reenter: got %b/%b expected 1/1", core_reset, dl_busy); end
    wr(25'd2, 8'h42);
    vectors++; if (rom_wr !== 1'b1 || rom_data !== 8'h42 || rom_addr !== 16'h2) begin miscompares++; $display("FAIL hold_reenter_rom: got %b/%h/%h expected 1/0002/42", rom_wr, rom_addr, rom_data); end
    finish_dl();
  endtask

  task automatic test_simultaneous();
    ioctl_index    = 8'd1;
    ioctl_download = 1'b1;
    wr(25'd0, 8'h03);
    tick();
    vectors++; if (mod !== 8'h03 || mod_onehot !== 4'b1000) begin miscompares++; $display("FAIL entry_write: got %h/%b expected 03/1000", mod, mod_onehot); end
    finish_dl();
    start_dl(8'd0);
    ioctl_download = 1'b0;
    wr(25'd5, 8'h99);
    vectors++; if (rom_wr !== 1'b1 || rom_addr !== 16'h5 || rom_data !== 8'h99) begin miscompares++; $display("FAIL fall_write: got %b/%h/%h expected 1/0005/99", rom_wr, rom_addr, rom_data); end
    repeat (4) tick();
    vectors++; if (dl_busy !== 1'b0) begin miscompares++; $display("FAIL fall_idle: got %b expected 0", dl_busy); end
    start_dl(8'd7);
    wr(25'd0, 8'h55);
    vectors++; if (rom_wr !== 1'b0 || mod !== 8'h03 || dl_busy !== 1'b1) begin miscompares++; $display("FAIL other_ignore: got wr=%b mod=%h busy=%b expected 0/03/1", rom_wr, mod, dl_busy); end
    finish_dl();
  endtask

  task automatic test_reset_mid();
    start_dl(8'd0);
    wr(25'd4, 8'hC3);
    reset = 1'b1;
    #1;
    vectors++; if (rom_wr !== 1'b0 || rom_addr !== 16'h0 || rom_data !== 8'h0) begin miscompares++; $display("FAIL midrst_rom: got %b/%h/%h expected 0/0000/00", rom_wr, rom_addr, rom_data); end
    vectors++; if (core_reset !== 1'b1 || dl_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_seq: got %b/%b expected 1/0", core_reset, dl_busy); end
    vectors++; if (mod !== 8'h0 || mod_onehot !== 4'b0001 || sw_flat !== DIPD) begin miscompares++; $display("FAIL midrst_cfg: got %h/%b/%h expected 00/0001/%h", mod, mod_onehot, sw_flat, DIPD); end
    tick();
    reset = 1'b0;
    tick();
    vectors++; if (dl_busy !== 1'b1) begin miscompares++; $display("FAIL midrst_reenter: got %b expected 1", dl_busy); end
    wr(25'd6, 8'h3E);
    vectors++; if (rom_wr !== 1'b1 || rom_addr !== 16'h6 || rom_data !== 8'h3E) begin miscompares++; $display("FAIL midrst_rom_wr: got %b/%h/%h expected 1/0006/3e", rom_wr, rom_addr, rom_data); end
    finish_dl();
  endtask

  initial begin
    test_reset();
    test_rom_basic();
    test_rom_overflow();
    test_mod();
    test_dip();
    test_hold();
    test_simultaneous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
